divider: RTL and testbench
==========================

# divider

Multi-cycle 32-bit MIPS integer divider for DIV/DIVU, sitting in the EX stage beside the ALU and feeding the same HI/LO write path as the ALU multiply results. Runs a radix-2 restoring division over 32 iterations. While it runs, it holds the pipeline with `stall`. It returns quotient to LO and remainder to HI.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  the EX stage holds this high while a DIV/DIVU is in EX.
- `signed_div`  in  1  1 selects DIV (signed), 0 selects DIVU.
- `a`  in  32  dividend (rs).
- `b`  in  32  divisor (rt).
- `annul`  in  1  flush from an exception or branch. Aborts the current division.
- `stall`  out  1  combinational request to freeze IF/ID/EX.
- `ready`  out  1  registered. Results are valid while this is high.
- `result_hi`  out  32  registered remainder, written to HI.
- `result_lo`  out  32  registered quotient, written to LO.

## Operation
- FSM states: IDLE, DIVZERO, ON, END. Reset state is IDLE.
- IDLE:
  - `start=1` with `annul=0` and `b!=0`: latch `|a|` and `|b|` (absolute values only when `signed_div=1`). Also latch the sign flags `qneg = a[31]^b[31]` and `rneg = a[31]`, both gated by `signed_div`. Clear the 65-bit partial register and the 6-bit counter. Go to ON.
  - `start=1` with `annul=0` and `b==0`: go to DIVZERO.
- DIVZERO: load `result_hi = result_lo = 0` and go to END. The team defines divide-by-zero as returning zero, with no trap.
- ON: each cycle performs one restoring step:
  - Shift the partial remainder left by 1.
  - Trial-subtract the divisor (33-bit subtract).
  - If the result is non-negative, keep it and shift in quotient bit 1. Otherwise keep the shifted value and shift in 0.
  - After the 32nd step, apply the sign fix-up: negate the quotient if `qneg`, negate the remainder if `rneg` (two's complement, 32-bit wrap). Register the results and go to END.
- END: `ready=1`. Stay in END while `start=1`. Go to IDLE when `start=0`.
- `annul=1` in any state: go to IDLE next cycle. This takes priority over all other transitions. `ready` drops next cycle. Results already in `result_hi`/`result_lo` are left unchanged.
- `stall` is defined as `(IDLE & start & ~annul) | DIVZERO | ON`. It is 0 in END so the pipeline can advance with the results. It is forced to 0 while `rst=1`.
- Arithmetic rules:
  - The signed overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0, with no exception.
  - The remainder always takes the dividend's sign.

## Timing
- Reset: FSM=IDLE, `ready=0`, `result_hi=0`, `result_lo=0`, `stall=0`, counter=0.
- `rst` has priority over everything. Asserting it mid-division returns to IDLE next edge with outputs at their reset values.
- Normal division, with start sampled in IDLE at edge T:
  - ON for cycles T+1..T+32.
  - END from T+33, so `ready=1` at T+33.
  - `stall` is high over T..T+32: 33 stall cycles.
- Divide by zero: DIVZERO at T+1, END at T+2. `stall` is high over T..T+1.
- `start` held through END: `ready` stays high and the results are stable. A new division begins only after one IDLE cycle.
- `annul` asserted at cycle Tx during ON: IDLE at Tx+1. A `start` seen in IDLE at Tx+1 begins a fresh division.

## Structure
- Shared package (or `defines2.vh`): `EXE_DIV_OP`/`EXE_DIVU_OP` opcodes, the FSM state encoding (2-bit), and the `WIDTH` constant.
- One natural sub-module: `div_step`. It is combinational: it takes the partial remainder and divisor and outputs the next partial remainder and the quotient bit.
- The top level holds the FSM, counter, operand and sign registers, and the fix-up logic.

## Test plan
- DIVU a=100, b=7: `ready` at T+33 with LO=14, HI=2. `stall` high for exactly 33 cycles.
- DIV a=-7 (0xFFFFFFF9), b=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0, no hang.
- DIVU a=0x12345678, b=0: `ready` at T+2 with HI=LO=0. `stall` high for 2 cycles.
- DIVU a=0xFFFFFFFF, b=1 with `annul` at T+10: IDLE at T+11, `ready` never rises. Restart with the same operands: LO=0xFFFFFFFF, HI=0 at new T+33.
- `rst` asserted at T+5 of a division: all outputs 0 next edge. A subsequent DIVU 9/3 gives LO=3, HI=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared constants, opcodes, FSM encoding and a small sign helper for the
// multi-cycle HI/LO divider.
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_DIVZERO = 2'b01,
    ST_ON      = 2'b10,
    ST_END     = 2'b11
  } divState_t;

  // Two's complement negate when neg is set; 32-bit wrap is intended.
  function automatic logic [DIV_WIDTH-1:0] negIf(input logic neg,
                                                 input logic [DIV_WIDTH-1:0] v);
    return neg ? ((~v) + DIV_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/divider_if.sv
// EX-stage <-> divider bundle: request/operands in, stall/ready/results out.
interface divider_if;
  import divider_pkg::*;

  logic                 start;
  logic                 signed_div;
  logic [DIV_WIDTH-1:0] a;
  logic [DIV_WIDTH-1:0] b;
  logic                 annul;
  logic                 stall;
  logic                 ready;
  logic [DIV_WIDTH-1:0] result_hi;
  logic [DIV_WIDTH-1:0] result_lo;

  modport master (
    output start, signed_div, a, b, annul,
    input  stall, ready, result_hi, result_lo
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output stall, ready, result_hi, result_lo
  );

endinterface

// File: rtl/divider_div_step.sv
// One radix-2 restoring step: shift the {remainder,dividend/quotient} pair left,
// trial-subtract the divisor and keep the difference when it is non-negative.
module divider_div_step
  import divider_pkg::*;
(
  input  logic [2*DIV_WIDTH:0]   i_partial,
  input  logic [DIV_WIDTH-1:0]   i_divisor,
  output logic [2*DIV_WIDTH:0]   o_partial,
  output logic                   o_qbit
);

  logic [2*DIV_WIDTH:0] w_shifted;
  logic [DIV_WIDTH:0]   w_diff;

  // The shifted remainder can reach 33 bits, so the trial subtract is 33 wide.
  always_comb begin
    w_shifted = i_partial << 1;
    w_diff    = w_shifted[2*DIV_WIDTH:DIV_WIDTH] - {1'b0, i_divisor};
    o_qbit    = ~w_diff[DIV_WIDTH];
    o_partial = w_shifted;
    if (o_qbit) begin
      o_partial = {1'b0, w_diff[DIV_WIDTH-1:0], w_shifted[DIV_WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle DIV/DIVU unit: 32 restoring steps on operand magnitudes, then
// sign fix-up; quotient to LO, remainder to HI, pipeline held via stall.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
)(
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);

  divState_t          r_state;
  divState_t          w_nextState;
  logic [5:0]         r_count;
  logic [2*WIDTH:0]   r_partial;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_ready;
  logic [WIDTH-1:0]   r_resultHi;
  logic [WIDTH-1:0]   r_resultLo;

  logic               w_load;
  logic               w_lastStep;
  logic [2*WIDTH:0]   w_stepPartial;
  logic               w_stepQbit;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  divider_div_step u_step (
    .i_partial (r_partial),
    .i_divisor (r_divisor),
    .o_partial (w_stepPartial),
    .o_qbit    (w_stepQbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // annul overrides every transition, including the start of a new divide.
  always_comb begin
    w_nextState = r_state;
    if (bus.annul) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (bus.start) w_nextState = (bus.b == '0) ? ST_DIVZERO : ST_ON;
        ST_DIVZERO: w_nextState = ST_END;
        ST_ON:      if (w_lastStep) w_nextState = ST_END;
        ST_END:     if (!bus.start) w_nextState = ST_IDLE;
        default:    w_nextState = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load     = (r_state == ST_IDLE) && bus.start && !bus.annul && (bus.b != '0);
    w_lastStep = (r_count == 6'd31);
    w_absA     = negIf(bus.signed_div & bus.a[WIDTH-1], bus.a);
    w_absB     = negIf(bus.signed_div & bus.b[WIDTH-1], bus.b);
    w_quot     = negIf(r_qneg, w_stepPartial[WIDTH-1:0]);
    w_rem      = negIf(r_rneg, w_stepPartial[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_partial  <= '0;
      r_divisor  <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_ready    <= 1'b0;
      r_resultHi <= '0;
      r_resultLo <= '0;
    end else begin
      r_ready <= (w_nextState == ST_END);
      if (w_load) begin
        r_partial <= {{(WIDTH+1){1'b0}}, w_absA};
        r_divisor <= w_absB;
        r_qneg    <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        r_rneg    <= bus.signed_div & bus.a[WIDTH-1];
        r_count   <= '0;
      end else if (r_state == ST_ON && !bus.annul) begin
        r_partial <= w_stepPartial;
        r_count   <= r_count + 6'd1;
        if (w_lastStep) begin
          r_resultLo <= w_quot;
          r_resultHi <= w_rem;
        end
      end else if (r_state == ST_DIVZERO && !bus.annul) begin
        r_resultLo <= '0;
        r_resultHi <= '0;
      end
    end
  end

  always_comb begin
    bus.stall     = !rst && (((r_state == ST_IDLE) && bus.start && !bus.annul) ||
                             (r_state == ST_DIVZERO) || (r_state == ST_ON));
    bus.ready     = r_ready;
    bus.result_hi = r_resultHi;
    bus.result_lo = r_resultLo;
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed MIPS DIV/DIVU cases plus random
// operands compared against a plain-arithmetic reference.
module tb_divider;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   divider_if divIf ();

   divider u_dut (
      .clk (clk),
      .rst (rst),
      .bus (divIf)
   );

   // free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // hard stop so a hung design still ends with a reported failure
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time exhausted");
      $fatal(1, "[TB] watchdog expired");
   end

   // reference: HI/LO as MIPS defines them, zero for divide by zero
   function automatic void refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      longint lq;
      longint lr;
      if (b == 32'd0) begin
         q = 32'd0;
         r = 32'd0;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lq = sa / sb;
         lr = sa % sb;
         q  = lq[31:0];
         r  = lr[31:0];
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // raise start for a new op, then count stall cycles until ready (bounded)
   task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output int latency, output int stallCycles);
      @(posedge clk);
      #1;
      divIf.signed_div = sgn;
      divIf.a          = a;
      divIf.b          = b;
      divIf.annul      = 1'b0;
      divIf.start      = 1'b1;
      latency          = -1;
      stallCycles      = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (divIf.ready === 1'b1) begin
            latency = i;
            break;
         end
         if (divIf.stall === 1'b1) stallCycles++;
      end
   endtask

   // drop start and let the FSM pass through END back to IDLE
   task automatic releaseStart();
      @(posedge clk);
      #1;
      divIf.start = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // reset values, and stall must stay low while rst is high even with start
   task automatic test_reset();
      rst              = 1'b1;
      divIf.start      = 1'b0;
      divIf.signed_div = 1'b0;
      divIf.a          = 32'd100;
      divIf.b          = 32'd7;
      divIf.annul      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      divIf.start = 1'b1;
      @(negedge clk);
      checks++;
      if (divIf.stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_stall: got %b expected 0", divIf.stall);
      end
      checks++;
      if (divIf.ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b expected 0", divIf.ready);
      end
      checks++;
      if (divIf.result_hi !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_hi: got %h expected 00000000", divIf.result_hi);
      end
      checks++;
      if (divIf.result_lo !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_lo: got %h expected 00000000", divIf.result_lo);
      end
      @(posedge clk);
      #1;
      divIf.start = 1'b0;
      rst         = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // the specified directed cases, including overflow and divide by zero
   task automatic test_directed();
      bit          sgnTab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] aTab   [4] = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'h12345678};
      logic [31:0] bTab   [4] = '{32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
      logic [31:0] qExp;
      logic [31:0] rExp;
      int          lat;
      int          stl;
      int          latExp;
      for (int k = 0; k < 4; k++) begin
         refDiv(sgnTab[k], aTab[k], bTab[k], qExp, rExp);
         latExp = (bTab[k] == 32'd0) ? 2 : 33;
         applyStimulus(sgnTab[k], aTab[k], bTab[k], lat, stl);
         checks++;
         if (lat !== latExp) begin
            errors++;
            $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", k, lat, latExp);
         end
         checks++;
         if (stl !== latExp) begin
            errors++;
            $display("[TB] FAIL directed%0d_stall: got %0d cycles expected %0d", k, stl, latExp);
         end
         checks++;
         if (divIf.result_lo !== qExp) begin
            errors++;
            $display("[TB] FAIL directed%0d_lo: got %h expected %h", k, divIf.result_lo, qExp);
         end
         checks++;
         if (divIf.result_hi !== rExp) begin
            errors++;
            $display("[TB] FAIL directed%0d_hi: got %h expected %h", k, divIf.result_hi, rExp);
         end
         releaseStart();
      end
   endtask

   // random signed/unsigned operands with a bias toward small and zero divisors
   task automatic test_random();
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] qExp;
      logic [31:0] rExp;
      int          lat;
      int          stl;
      int          latExp;
      for (int k = 0; k < 30; k++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'd0 - 32'($urandom_range(1, 15));
            default: b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         endcase
         refDiv(sgn, a, b, qExp, rExp);
         latExp = (b == 32'd0) ? 2 : 33;
         applyStimulus(sgn, a, b, lat, stl);
         checks++;
         if (lat !== latExp || stl !== latExp) begin
            errors++;
            $display("[TB] FAIL random%0d_timing: got latency %0d stall %0d expected %0d", k, lat, stl, latExp);
         end
         checks++;
         if (divIf.result_lo !== qExp || divIf.result_hi !== rExp) begin
            errors++;
            $display("[TB] FAIL random%0d_result: sgn=%0d a=%h b=%h got lo=%h hi=%h expected lo=%h hi=%h",
                     k, sgn, a, b, divIf.result_lo, divIf.result_hi, qExp, rExp);
         end
         releaseStart();
      end
   endtask

   // start held through END keeps results stable; IDLE is visited before next op
   task automatic test_back_to_back();
      logic [31:0] qExp;
      logic [31:0] rExp;
      int          lat;
      int          stl;
      int          badCycles;
      refDiv(1'b1, 32'd1000, 32'hFFFFFFFD, qExp, rExp);
      applyStimulus(1'b1, 32'd1000, 32'hFFFFFFFD, lat, stl);
      badCycles = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (divIf.ready !== 1'b1 || divIf.stall !== 1'b0 ||
             divIf.result_lo !== qExp || divIf.result_hi !== rExp) badCycles++;
      end
      checks++;
      if (badCycles !== 0) begin
         errors++;
         $display("[TB] FAIL hold_stable: got %0d bad cycles expected 0 (lo=%h hi=%h want %h %h)",
                  badCycles, divIf.result_lo, divIf.result_hi, qExp, rExp);
      end
      releaseStart();
      checks++;
      if (divIf.ready !== 1'b0 || divIf.stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_release: got ready=%b stall=%b expected 0 0", divIf.ready, divIf.stall);
      end
      refDiv(1'b0, 32'hDEADBEEF, 32'd16, qExp, rExp);
      applyStimulus(1'b0, 32'hDEADBEEF, 32'd16, lat, stl);
      checks++;
      if (lat !== 33 || divIf.result_lo !== qExp || divIf.result_hi !== rExp) begin
         errors++;
         $display("[TB] FAIL back_to_back: got latency %0d lo=%h hi=%h expected 33 lo=%h hi=%h",
                  lat, divIf.result_lo, divIf.result_hi, qExp, rExp);
      end
      releaseStart();
   endtask

   // annul mid-division aborts without touching results; a restart completes
   task automatic test_annul();
      logic [31:0] oldHi;
      logic [31:0] oldLo;
      int          lat;
      int          stl;
      int          readySeen;
      oldHi = divIf.result_hi;
      oldLo = divIf.result_lo;
      @(posedge clk);
      #1;
      divIf.signed_div = 1'b0;
      divIf.a          = 32'hFFFFFFFF;
      divIf.b          = 32'd1;
      divIf.start      = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      divIf.annul = 1'b1;
      divIf.start = 1'b0;
      @(posedge clk);
      #1;
      divIf.annul = 1'b0;
      checks++;
      if (divIf.stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL annul_idle_stall: got %b expected 0", divIf.stall);
      end
      readySeen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (divIf.ready !== 1'b0) readySeen++;
      end
      checks++;
      if (readySeen !== 0) begin
         errors++;
         $display("[TB] FAIL annul_ready: got %0d ready cycles expected 0", readySeen);
      end
      checks++;
      if (divIf.result_hi !== oldHi || divIf.result_lo !== oldLo) begin
         errors++;
         $display("[TB] FAIL annul_results: got hi=%h lo=%h expected hi=%h lo=%h",
                  divIf.result_hi, divIf.result_lo, oldHi, oldLo);
      end
      @(posedge clk);
      #1;
      divIf.start = 1'b1;
      divIf.annul = 1'b1;
      @(negedge clk);
      checks++;
      if (divIf.stall !== 1'b0) begin
         errors++;
         $display("[TB] FAIL annul_start_stall: got %b expected 0", divIf.stall);
      end
      @(posedge clk);
      #1;
      divIf.start = 1'b0;
      divIf.annul = 1'b0;
      applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, lat, stl);
      checks++;
      if (lat !== 33 || divIf.result_lo !== 32'hFFFFFFFF || divIf.result_hi !== 32'd0) begin
         errors++;
         $display("[TB] FAIL annul_restart: got latency %0d lo=%h hi=%h expected 33 lo=ffffffff hi=00000000",
                  lat, divIf.result_lo, divIf.result_hi);
      end
      releaseStart();
   endtask

   // synchronous reset in the middle of a division, then a clean 9/3
   task automatic test_reset_mid();
      int lat;
      int stl;
      @(posedge clk);
      #1;
      divIf.signed_div = 1'b0;
      divIf.a          = 32'd1000;
      divIf.b          = 32'd3;
      divIf.start      = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (divIf.stall !== 1'b0 || divIf.ready !== 1'b0 ||
          divIf.result_hi !== 32'd0 || divIf.result_lo !== 32'd0) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: got stall=%b ready=%b hi=%h lo=%h expected all zero",
                  divIf.stall, divIf.ready, divIf.result_hi, divIf.result_lo);
      end
      rst         = 1'b0;
      divIf.start = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 32'd9, 32'd3, lat, stl);
      checks++;
      if (lat !== 33 || divIf.result_lo !== 32'd3 || divIf.result_hi !== 32'd0) begin
         errors++;
         $display("[TB] FAIL midreset_9div3: got latency %0d lo=%h hi=%h expected 33 lo=00000003 hi=00000000",
                  lat, divIf.result_lo, divIf.result_hi);
      end
      releaseStart();
   endtask

   // scenario sequence and the single summary line
   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_annul();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
